// File: rtl/uart_msg_pkg.sv
// Shared constants, encodings and field helpers for the UART message parser.
package uart_msg_pkg;

  localparam logic [7:0] CH_S    = 8'h53;
  localparam logic [7:0] CH_I    = 8'h49;
  localparam logic [7:0] CH_N    = 8'h4E;
  localparam logic [7:0] CH_E    = 8'h45;
  localparam logic [7:0] CH_W    = 8'h57;
  localparam logic [7:0] CH_P    = 8'h50;
  localparam logic [7:0] CH_D    = 8'h44;
  localparam logic [7:0] CH_Z    = 8'h5A;
  localparam logic [7:0] CH_DASH = 8'h2D;
  localparam logic [7:0] CH_HASH = 8'h23;
  localparam logic [7:0] CH_CR   = 8'h0D;
  localparam logic [7:0] CH_LF   = 8'h0A;
  localparam logic [7:0] CH_0    = 8'h30;
  localparam logic [7:0] CH_1    = 8'h31;
  localparam logic [7:0] CH_9    = 8'h39;

  localparam logic [2:0] DIR_N = 3'd0;
  localparam logic [2:0] DIR_E = 3'd1;
  localparam logic [2:0] DIR_S = 3'd2;
  localparam logic [2:0] DIR_W = 3'd3;
  localparam logic [2:0] DIR_P = 3'd4;

  localparam logic [1:0] ERR_FORMAT   = 2'd0;
  localparam logic [1:0] ERR_OVERFLOW = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT  = 2'd2;

  localparam logic MSG_SI = 1'b0;
  localparam logic MSG_S  = 1'b1;

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_COLLECT = 2'd1;
  localparam logic [1:0] ST_DROP    = 2'd2;
  localparam logic [1:0] ST_CHECK   = 2'd3;

  typedef struct packed {
    logic       msg_type;
    logic [3:0] unit;
    logic [2:0] dir;
    logic       action;
  } msg_fields_t;

  function automatic logic is_digit(input logic [7:0] b);
    return (b >= CH_1) && (b <= CH_9);
  endfunction

  function automatic logic is_dir(input logic [7:0] b);
    return (b == CH_N) || (b == CH_E) || (b == CH_S) || (b == CH_W) || (b == CH_P);
  endfunction

  function automatic logic [2:0] dir_code(input logic [7:0] b);
    logic [2:0] d;
    d = DIR_N;
    case (b)
      CH_E:    d = DIR_E;
      CH_S:    d = DIR_S;
      CH_W:    d = DIR_W;
      CH_P:    d = DIR_P;
      default: d = DIR_N;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/msg_template_match.sv
// Combinational match of a stored frame against the SI and S message templates.
module msg_template_match
  import uart_msg_pkg::*;
#(
  parameter int unsigned MAX_LEN = 16,
  localparam int unsigned CW = $clog2(MAX_LEN + 1)
) (
  input  logic [MAX_LEN-1:0][7:0] frame_buf,
  input  logic [CW-1:0]           count,
  output logic                    ok,
  output msg_fields_t             fields
);

  logic si_ok;
  logic s_ok;

  always_comb begin
    si_ok = (count == CW'(10)) &&
            (frame_buf[0] == CH_S) && (frame_buf[1] == CH_I) && (frame_buf[2] == CH_DASH) &&
            (frame_buf[3] == CH_S) && (frame_buf[4] == CH_I) && (frame_buf[5] == CH_N) &&
            is_digit(frame_buf[6]) && (frame_buf[7] == CH_DASH) &&
            is_dir(frame_buf[8]) && (frame_buf[9] == CH_DASH);
    s_ok  = (count == CW'(11)) &&
            (frame_buf[0] == CH_S) && (frame_buf[1] == CH_DASH) &&
            ((frame_buf[2] == CH_P) || (frame_buf[2] == CH_D)) && (frame_buf[3] == CH_DASH) &&
            (frame_buf[4] == CH_D) && (frame_buf[5] == CH_Z) && (frame_buf[6] == CH_N) &&
            is_digit(frame_buf[7]) && (frame_buf[8] == CH_DASH) &&
            is_dir(frame_buf[9]) && (frame_buf[10] == CH_DASH);
  end

  // Field positions differ by one byte between the two templates.
  always_comb begin
    ok              = si_ok || s_ok;
    fields.msg_type = s_ok ? MSG_S : MSG_SI;
    fields.unit     = s_ok ? 4'(frame_buf[7] - CH_0) : 4'(frame_buf[6] - CH_0);
    fields.dir      = s_ok ? dir_code(frame_buf[9]) : dir_code(frame_buf[8]);
    fields.action   = s_ok && (frame_buf[2] == CH_D);
  end

  if (MAX_LEN > 11) begin : g_tail
    logic unused_tail;
    assign unused_tail = ^frame_buf[MAX_LEN-1:11];
  end

endmodule

// File: rtl/uart_msg_parser.sv
// Frames UART RX bytes on '#', validates SI/S messages, pulses msg_valid or msg_err.
// Define UART_MSG_STATS_EN to add saturating good_cnt/bad_cnt frame counters.
module uart_msg_parser
  import uart_msg_pkg::*;
#(
  parameter int unsigned MAX_LEN     = 16,
  parameter int unsigned TIMEOUT_CYC = 50000000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx_data_valid,
  input  logic [7:0] rx_byte,
  output logic       msg_valid,
  output logic       msg_type,
  output logic [3:0] unit,
  output logic [2:0] dir,
  output logic       action,
  output logic       msg_err,
  output logic [1:0] err_code
`ifdef UART_MSG_STATS_EN
  ,
  output logic [7:0] good_cnt,
  output logic [7:0] bad_cnt
`endif
);

  localparam int unsigned CW = $clog2(MAX_LEN + 1);
  localparam int unsigned IW = $clog2(MAX_LEN);
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);

  logic [1:0]              state_q, state_nx;
  logic [CW-1:0]           count_q, count_nx;
  logic [TW-1:0]           tcnt_q, tcnt_nx;
  logic                    ovf_q, ovf_nx;
  logic [MAX_LEN-1:0][7:0] frame_buf;
  logic                    wr_en;
  logic [IW-1:0]           wr_idx;
  logic                    valid_nx, err_nx;
  logic [1:0]              code_nx;
  msg_fields_t             fields_q, fields_nx, m_fields;
  logic                    m_ok;
  logic                    is_hash, is_crlf;

  msg_template_match #(.MAX_LEN(MAX_LEN)) u_match (
    .frame_buf (frame_buf),
    .count     (count_q),
    .ok        (m_ok),
    .fields    (m_fields)
  );

  assign is_hash = (rx_byte == CH_HASH);
  assign is_crlf = (rx_byte == CH_CR) || (rx_byte == CH_LF);

  // Next-state and next-output logic; CHECK reports and also accepts byte 0 of the next frame.
  always_comb begin
    state_nx  = state_q;
    count_nx  = count_q;
    tcnt_nx   = tcnt_q;
    ovf_nx    = ovf_q;
    wr_en     = 1'b0;
    wr_idx    = '0;
    valid_nx  = 1'b0;
    err_nx    = 1'b0;
    code_nx   = err_code;
    fields_nx = fields_q;
    case (state_q)
      ST_IDLE, ST_CHECK: begin
        if (state_q == ST_CHECK) begin
          if (ovf_q) begin
            err_nx  = 1'b1;
            code_nx = ERR_OVERFLOW;
          end else if (m_ok) begin
            valid_nx  = 1'b1;
            fields_nx = m_fields;
          end else begin
            err_nx  = 1'b1;
            code_nx = ERR_FORMAT;
          end
        end
        state_nx = ST_IDLE;
        count_nx = '0;
        tcnt_nx  = '0;
        ovf_nx   = 1'b0;
        if (rx_data_valid) begin
          if (is_hash) begin
            state_nx = ST_CHECK;
          end else if (!is_crlf) begin
            wr_en    = 1'b1;
            count_nx = CW'(1);
            state_nx = ST_COLLECT;
          end
        end
      end
      ST_COLLECT, ST_DROP: begin
        if (rx_data_valid) begin
          tcnt_nx = '0;
          if (is_hash) begin
            state_nx = ST_CHECK;
          end else if (state_q == ST_COLLECT) begin
            if (count_q == CW'(MAX_LEN)) begin
              state_nx = ST_DROP;
              ovf_nx   = 1'b1;
            end else begin
              wr_en    = 1'b1;
              wr_idx   = IW'(count_q);
              count_nx = count_q + CW'(1);
            end
          end
        end else if (tcnt_q == TW'(TIMEOUT_CYC - 1)) begin
          err_nx   = 1'b1;
          code_nx  = ERR_TIMEOUT;
          state_nx = ST_IDLE;
          ovf_nx   = 1'b0;
        end else begin
          tcnt_nx = tcnt_q + TW'(1);
        end
      end
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      tcnt_q    <= '0;
      ovf_q     <= 1'b0;
      msg_valid <= 1'b0;
      msg_err   <= 1'b0;
      err_code  <= ERR_FORMAT;
      fields_q  <= '0;
    end else begin
      state_q   <= state_nx;
      count_q   <= count_nx;
      tcnt_q    <= tcnt_nx;
      ovf_q     <= ovf_nx;
      msg_valid <= valid_nx;
      msg_err   <= err_nx;
      err_code  <= code_nx;
      fields_q  <= fields_nx;
    end
  end

  // Frame storage needs no reset: only bytes below count are ever matched.
  always_ff @(posedge clk) begin
    if (wr_en) frame_buf[wr_idx] <= rx_byte;
  end

  assign msg_type = fields_q.msg_type;
  assign unit     = fields_q.unit;
  assign dir      = fields_q.dir;
  assign action   = fields_q.action;

`ifdef UART_MSG_STATS_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      good_cnt <= '0;
      bad_cnt  <= '0;
    end else begin
      if (valid_nx && (good_cnt != 8'hFF)) good_cnt <= good_cnt + 8'd1;
      if (err_nx && (bad_cnt != 8'hFF))    bad_cnt  <= bad_cnt + 8'd1;
    end
  end
`else
  // Statistics counters are absent in this build.
`endif

endmodule

// File: doc/uart_msg_parser.md
Name: uart_msg_parser

Overview:
- Receive-side counterpart of the UART message transmitter.
- Consumes bytes from the UART RX core (one-cycle rx_data_valid strobe per byte) and frames them on the '#' terminator.
- Validates each frame against the two codebase message formats, "SI-SIN<d>-<c>-#" and "S-<a>-DZN<d>-<c>-#".
- Presents decoded fields with a one-cycle msg_valid pulse, or a one-cycle msg_err pulse with a reason code.

Parameters:
- MAX_LEN, 16: maximum stored bytes per frame, excluding '#'.
- TIMEOUT_CYC, 50000000: idle clock cycles allowed between bytes inside a frame before the frame is aborted.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- rx_data_valid  in  1  one-cycle strobe: rx_byte is valid
- rx_byte  in  8  received byte
- msg_valid  out  1  one-cycle pulse: decoded fields updated
- msg_type  out  1  0 = SI (status), 1 = S (supply)
- unit  out  4  unit/zone digit, 1..9
- dir  out  3  N=0, E=1, S=2, W=3, P=4
- action  out  1  0 = pick 'P', 1 = depose 'D'; 0 for SI frames
- msg_err  out  1  one-cycle pulse: frame rejected
- err_code  out  2  0 = format, 1 = overflow, 2 = timeout

Behaviour:
- Reset values: all outputs 0, FSM in IDLE, byte count 0, timeout counter 0.
- Reset mid-frame discards the partial frame and raises no error pulse.
- States: IDLE, COLLECT, DROP, CHECK.
- IDLE:
  - Bytes 0x0D and 0x0A are ignored (the transmitter appends CR).
  - '#' alone gives msg_err code 0.
  - Any other byte is stored at index 0, count=1, next state COLLECT.
- COLLECT:
  - A non-'#' byte with count < MAX_LEN is stored at index count and count increments.
  - A non-'#' byte with count == MAX_LEN moves to DROP.
  - '#' moves to CHECK.
  - CR/LF inside a frame is stored like any other byte, so the frame fails format.
- DROP: discard bytes until '#'; on '#', msg_err with code 1, then IDLE.
- CHECK: a single cycle in which the stored buffer is matched, then IDLE.
  - SI frame: count == 10; bytes 'S','I','-','S','I','N',d,'-',c,'-'.
  - S frame: count == 11; bytes 'S','-',a,'-','D','Z','N',d,'-',c,'-'.
  - Field values: d in '1'..'9', unit = d - 0x30; c in {N,E,S,W,P}; a in {P,D}.
  - Any mismatch gives msg_err with code 0.
- Latency and output timing:
  - '#' sampled at edge k; CHECK occupies cycle k..k+1.
  - msg_valid or msg_err is registered at edge k+1 and is high for exactly one cycle.
  - Field outputs update only with msg_valid and hold until the next msg_valid.
  - err_code updates only with msg_err and holds.
- Byte during CHECK: accepted as byte 0 of the next frame, with the same CR/LF/'#' rules as IDLE. The current decode is unaffected.
- Timeout:
  - The counter runs in COLLECT and DROP and clears on every accepted byte.
  - When it reaches TIMEOUT_CYC-1 with no byte that cycle: msg_err with code 2, then IDLE.
  - A byte arriving in the same cycle wins; no timeout is raised.
- msg_valid and msg_err are never high together.
- Counter width is $clog2(TIMEOUT_CYC+1); the byte count is $clog2(MAX_LEN+1) bits.

Optional Feature:
- Macro: UART_MSG_STATS_EN.
- When defined:
  - Adds outputs good_cnt[7:0] and bad_cnt[7:0].
  - good_cnt increments on each msg_valid; bad_cnt increments on each msg_err.
  - Both saturate at 255 and clear on rst.
- When undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package uart_msg_pkg holds:
  - ASCII constants: CH_S, CH_I, CH_N, CH_DASH, CH_HASH, CH_CR, CH_LF, CH_D, CH_Z, CH_P and direction letters.
  - Direction encodings DIR_N..DIR_P.
  - Error codes ERR_FORMAT, ERR_OVERFLOW, ERR_TIMEOUT.
  - MSG_SI and MSG_S; the FSM state encoding.
- Sub-module msg_template_match: combinational check of the buffer and count against both templates. It returns ok, type, unit, dir and action.
- The parser top keeps the FSM, buffer, timeout counter and output registers.

Test Plan:
- Send "SI-SIN2-P-#" then 0x0D -> one msg_valid pulse one cycle after '#'. Expect msg_type=0, unit=2, dir=4, action=0, no msg_err; the CR produces nothing.
- Send "S-D-DZN1-N-#" -> msg_valid with msg_type=1, unit=1, dir=0, action=1.
- Send "SI-SIN0-P-#", then "S-X-DZN1-N-#" -> two msg_err pulses, each with err_code=0. Fields keep their previous values.
- With MAX_LEN=16, send 20 bytes 'A' then '#' -> exactly one msg_err with err_code=1, asserted at the '#'. No pulse before the '#'.
- With TIMEOUT_CYC=100, send "SI-S" then 100 idle cycles -> msg_err with err_code=2. A following "SI-SIN3-W-#" decodes with unit=3, dir=3.
- Send "S-P-", assert rst for 1 cycle, then send "DZN1-N-#" -> no pulse at reset, then msg_err with err_code=0. With UART_MSG_STATS_EN defined, expect bad_cnt=1 and good_cnt=0.
